trng_fetch: RTL and testbench



---
 rtl/trng_fetch_if.sv | 12 +
 rtl/trng_fetch.sv | 171 +++++++++++++++++
 tb/tb_trng_fetch.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_fetch_if.sv
// Single-cycle register bus between the trng_fetch initiator and the TRNG slave.
`timescale 1ns/1ps
interface trng_fetch_if;
  logic        SEL_O;
  logic [31:0] ADDR_O;
  logic        WRITE_O;
  logic [31:0] WDATA_O;
  logic [31:0] RDATA_I;

  modport master (output SEL_O, ADDR_O, WRITE_O, WDATA_O, input RDATA_I);
  modport slave  (input SEL_O, ADDR_O, WRITE_O, WDATA_O, output RDATA_I);
endinterface

// File: rtl/trng_fetch.sv
// TRNG fetch engine: enables the generator, polls STATUS, reads DATA words and
// buffers them in a small FIFO exposed as a valid/ready entropy stream.
`timescale 1ns/1ps
module trng_fetch #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          POLL_GAP   = 8,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                          CLK_I,
  input  logic                          RESETN_I,
  input  logic                          EN_I,
  trng_fetch_if.master                  bus,
  output logic [31:0]                   DATA_O,
  output logic                          VALID_O,
  input  logic                          READY_I,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL_O,
  output logic                          ERR_O,
  input  logic                          CLR_ERR_I
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL     = LW'(FIFO_DEPTH);
  localparam logic [7:0]    GAP_LAST     = 8'(POLL_GAP - 1);
  localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0]   CTRL_ADDR    = BASE_ADDR;
  localparam logic [31:0]   STATUS_ADDR  = BASE_ADDR + 32'h4;
  localparam logic [31:0]   DATA_ADDR    = BASE_ADDR + 32'h8;

  typedef enum logic [2:0] {IDLE, START, POLL, PWAIT, GAP, RDDATA, DWAIT, STOP} state_t;

  state_t        state;
  logic [7:0]    gap_cnt;
  logic [15:0]   to_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic          push, pop;

  // Bus outputs are loaded on entry to the state that owns the transaction,
  // so each one is visible for exactly the cycle spent in that state.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      bus.SEL_O   <= 1'b0;
      bus.ADDR_O  <= '0;
      bus.WRITE_O <= 1'b0;
      bus.WDATA_O <= '0;
    end else begin
      bus.SEL_O   <= 1'b0;
      bus.ADDR_O  <= '0;
      bus.WRITE_O <= 1'b0;
      bus.WDATA_O <= '0;
      case (state)
        IDLE: if (EN_I) begin
          state       <= START;
          bus.SEL_O   <= 1'b1;
          bus.ADDR_O  <= CTRL_ADDR;
          bus.WRITE_O <= 1'b1;
          bus.WDATA_O <= 32'h1;
        end
        START: begin
          state      <= POLL;
          bus.SEL_O  <= 1'b1;
          bus.ADDR_O <= STATUS_ADDR;
        end
        POLL: state <= PWAIT;
        PWAIT: begin
          if (!EN_I) begin
            state       <= STOP;
            bus.SEL_O   <= 1'b1;
            bus.ADDR_O  <= CTRL_ADDR;
            bus.WRITE_O <= 1'b1;
          end else if (bus.RDATA_I[0] && (LEVEL_O < LVL_FULL)) begin
            state      <= RDDATA;
            bus.SEL_O  <= 1'b1;
            bus.ADDR_O <= DATA_ADDR;
          end else begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (!EN_I) begin
            state       <= STOP;
            bus.SEL_O   <= 1'b1;
            bus.ADDR_O  <= CTRL_ADDR;
            bus.WRITE_O <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state      <= POLL;
            bus.SEL_O  <= 1'b1;
            bus.ADDR_O <= STATUS_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        RDDATA: state <= DWAIT;
        DWAIT: begin
          bus.SEL_O <= 1'b1;
          if (!EN_I) begin
            state       <= STOP;
            bus.ADDR_O  <= CTRL_ADDR;
            bus.WRITE_O <= 1'b1;
          end else begin
            state      <= POLL;
            bus.ADDR_O <= STATUS_ADDR;
          end
        end
        STOP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      to_cnt <= '0;
      ERR_O  <= 1'b0;
    end else if (CLR_ERR_I) begin
      to_cnt <= '0;
      ERR_O  <= 1'b0;
    end else if (state == PWAIT) begin
      if (bus.RDATA_I[0]) begin
        to_cnt <= '0;
      end else if (to_cnt == TIMEOUT_LAST) begin
        to_cnt <= '0;
        ERR_O  <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  assign pop     = VALID_O & READY_I;
  assign push    = (state == DWAIT) && ((LEVEL_O != LVL_FULL) || pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= bus.RDATA_I;
  end

  // DATA_O is a registered copy of the head: on a pop it takes the next stored
  // word, or the word being pushed when the FIFO held only one entry.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      LEVEL_O <= '0;
      VALID_O <= 1'b0;
      DATA_O  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop) begin
        LEVEL_O <= LEVEL_O + 1'b1;
        VALID_O <= 1'b1;
      end else if (pop && !push) begin
        LEVEL_O <= LEVEL_O - 1'b1;
        VALID_O <= (LEVEL_O != LW'(1));
      end
      if (pop) begin
        if (LEVEL_O > LW'(1)) DATA_O <= mem[rd_next];
        else if (push)        DATA_O <= bus.RDATA_I;
      end else if (push && (LEVEL_O == '0)) begin
        DATA_O <= bus.RDATA_I;
      end
    end
  end

endmodule

// File: tb/tb_trng_fetch.sv
// Bench for trng_fetch: TRNG slave model, stream scoreboard, bus schedule rules,
// bring-up vector table, directed corner sequences and a randomized run.
`timescale 1ns/1ps
module tb_trng_fetch;

  localparam logic [31:0] BASE  = 32'h4000_1000;
  localparam int          DEPTH = 4;
  localparam int          GAP   = 3;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic [2:0]  level;
  logic        err;

  trng_fetch_if bus();

  trng_fetch #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .CLK_I(clk), .RESETN_I(rst_n), .EN_I(en), .bus(bus),
    .DATA_O(data), .VALID_O(valid), .READY_I(ready), .LEVEL_O(level),
    .ERR_O(err), .CLR_ERR_I(clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] fifo_q[$];
  int          timeout_cnt;
  bit          exp_err;
  bit          status_ready;
  logic [31:0] next_word;
  int          resp_kind;
  logic [31:0] resp_val;
  logic        p_sel, p_write;
  logic [31:0] p_addr, p_wdata;
  bit          sched_on;
  int          sched_cyc;
  logic [31:0] sched_addr;
  int          cyc;
  int          nready_cnt, data_reads, status_reads, pops;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        vld;
    int          lvl;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic resetModel();
    fifo_q.delete();
    timeout_cnt = 0;
    exp_err     = 1'b0;
    resp_kind   = 0;
    p_sel = 1'b0; p_write = 1'b0; p_addr = '0; p_wdata = '0;
    sched_on = 1'b0;
  endtask

  // Advance one clock: update the model with this cycle's inputs, then check
  // the new outputs and drive the slave's read response for the new cycle.
  task automatic step();
    int lvl_c;
    @(posedge clk); #1;
    lvl_c = fifo_q.size();
    if (ready && (lvl_c > 0)) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    if (resp_kind == 2) fifo_q.push_back(resp_val);
    if (clr) begin
      timeout_cnt = 0;
      exp_err     = 1'b0;
    end else if (resp_kind == 1) begin
      if (resp_val[0]) timeout_cnt = 0;
      else begin
        timeout_cnt++;
        if (timeout_cnt == TMO) begin
          exp_err     = 1'b1;
          timeout_cnt = 0;
        end
      end
    end
    if (!en) sched_on = 1'b0;
    else if (resp_kind == 1) begin
      sched_on = 1'b1;
      if (resp_val[0] && (lvl_c < DEPTH)) begin
        sched_cyc = cyc + 1; sched_addr = BASE + 32'h8;
      end else begin
        sched_cyc = cyc + 1 + GAP; sched_addr = BASE + 32'h4;
      end
    end else if (resp_kind == 2) begin
      sched_on = 1'b1; sched_cyc = cyc + 1; sched_addr = BASE + 32'h4;
    end
    if (p_sel && p_write && (p_wdata == 32'h1)) begin
      sched_on = 1'b1; sched_cyc = cyc + 1; sched_addr = BASE + 32'h4;
    end
    cyc++;

    checkOutput("level", 32'(level), 32'(fifo_q.size()));
    checkOutput("valid", 32'(valid), 32'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) checkOutput("data", data, fifo_q[0]);
    checkOutput("err", 32'(err), 32'(exp_err));
    if (!bus.SEL_O) begin
      checkOutput("idle_addr", bus.ADDR_O, 32'h0);
      checkOutput("idle_wdata", bus.WDATA_O, 32'h0);
      checkOutput("idle_write", 32'(bus.WRITE_O), 32'h0);
    end else if (bus.WRITE_O) begin
      checkOutput("write_addr", bus.ADDR_O, BASE);
    end
    if (sched_on) begin
      if (cyc < sched_cyc) checkOutput("gap_quiet", 32'(bus.SEL_O), 32'h0);
      else begin
        checkOutput("sched_sel", 32'(bus.SEL_O), 32'h1);
        checkOutput("sched_addr", bus.ADDR_O, sched_addr);
        checkOutput("sched_read", 32'(bus.WRITE_O), 32'h0);
        sched_on = 1'b0;
      end
    end

    if (p_sel && !p_write && (p_addr == BASE + 32'h4)) begin
      resp_kind = 1; resp_val = {31'b0, status_ready}; status_reads++;
      if (!status_ready) nready_cnt++;
    end else if (p_sel && !p_write && (p_addr == BASE + 32'h8)) begin
      resp_kind = 2; resp_val = next_word; next_word = next_word + 32'h1; data_reads++;
    end else begin
      resp_kind = 0; resp_val = $urandom;
    end
    bus.RDATA_I = resp_val;
    p_sel = bus.SEL_O; p_write = bus.WRITE_O; p_addr = bus.ADDR_O; p_wdata = bus.WDATA_O;
  endtask

  task automatic applyStimulus(input logic e, input logic r, input logic c);
    en = e; ready = r; clr = c;
    step();
  endtask

  initial begin
    bit hit;
    int d0, s0, p0, sels;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, BASE,          32'h1, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, BASE + 32'h4,  32'h0, 1'b0, 0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 0, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, BASE + 32'h8,  32'h0, 1'b0, 0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 0, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, BASE + 32'h4,  32'h0, 1'b1, 1, 32'hA5A5_0001};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, BASE + 32'h8,  32'h0, 1'b0, 0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, BASE + 32'h4,  32'h0, 1'b1, 1, 32'hA5A5_0002};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 0, 32'h0};

    resetModel();
    status_ready = 1'b1;
    next_word = 32'hA5A5_0001;
    nready_cnt = 0; data_reads = 0; status_reads = 0; pops = 0; cyc = 0;
    bus.RDATA_I = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sel", 32'(bus.SEL_O), 32'h0);
    checkOutput("rst_addr", bus.ADDR_O, 32'h0);
    checkOutput("rst_valid", 32'(valid), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_data", data, 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    step();
    cyc = 0;

    $display("[TB] bring-up vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].en, vecs[i].rdy, 1'b0);
      checkOutput("tbl_sel", 32'(bus.SEL_O), 32'(vecs[i].sel));
      checkOutput("tbl_write", 32'(bus.WRITE_O), 32'(vecs[i].wr));
      checkOutput("tbl_addr", bus.ADDR_O, vecs[i].addr);
      checkOutput("tbl_wdata", bus.WDATA_O, vecs[i].wdata);
      checkOutput("tbl_valid", 32'(valid), 32'(vecs[i].vld));
      checkOutput("tbl_level", 32'(level), 32'(vecs[i].lvl));
      if (vecs[i].vld) checkOutput("tbl_data", data, vecs[i].data);
    end

    $display("[TB] fill FIFO with consumer stalled");
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      hit = (level == 3'd4);
    end
    checkOutput("fill_reached", 32'(hit), 32'h1);
    d0 = data_reads; s0 = status_reads;
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("full_no_data_reads", 32'(data_reads - d0), 32'h0);
    checkOutput("full_polls_continue", 32'(status_reads - s0 >= 4), 32'h1);
    p0 = pops; d0 = data_reads;
    repeat (40) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("drain_pops", 32'(pops - p0 >= 4), 32'h1);
    checkOutput("fetch_resumed", 32'(data_reads - d0 > 0), 32'h1);

    $display("[TB] timeout with STATUS never ready");
    status_ready = 1'b0;
    nready_cnt = 0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      hit = err;
    end
    checkOutput("err_reached", 32'(hit), 32'h1);
    checkOutput("err_after_polls", 32'(nready_cnt), 32'(TMO));
    nready_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("err_cleared", 32'(err), 32'h0);
    clr = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      hit = err;
    end
    checkOutput("err_again_reached", 32'(hit), 32'h1);
    checkOutput("err_again_polls", 32'(nready_cnt), 32'(TMO));
    status_ready = 1'b1;

    $display("[TB] drop enable during DATA read");
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      hit = bus.SEL_O && (bus.ADDR_O == BASE + 32'h8);
    end
    checkOutput("rddata_reached", 32'(hit), 32'h1);
    d0 = data_reads;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_dwait_sel", 32'(bus.SEL_O), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_sel", 32'(bus.SEL_O), 32'h1);
    checkOutput("stop_write", 32'(bus.WRITE_O), 32'h1);
    checkOutput("stop_addr", bus.ADDR_O, BASE);
    checkOutput("stop_wdata", bus.WDATA_O, 32'h0);
    checkOutput("stop_word_taken", 32'(data_reads - d0), 32'h1);
    sels = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (bus.SEL_O) sels++;
    end
    checkOutput("idle_no_sel", 32'(sels), 32'h0);

    $display("[TB] push and pop at level 2");
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      hit = bus.SEL_O && (bus.ADDR_O == BASE + 32'h8) && (level == 3'd2);
    end
    checkOutput("lvl2_rddata_reached", 32'(hit), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pushpop_level", 32'(level), 32'h2);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] reset during POLL with level 3");
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      hit = (level == 3'd3) && bus.SEL_O && (bus.ADDR_O == BASE + 32'h4);
    end
    checkOutput("lvl3_poll_reached", 32'(hit), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sel", 32'(bus.SEL_O), 32'h0);
    checkOutput("mid_rst_addr", bus.ADDR_O, 32'h0);
    checkOutput("mid_rst_valid", 32'(valid), 32'h0);
    checkOutput("mid_rst_level", 32'(level), 32'h0);
    checkOutput("mid_rst_data", data, 32'h0);
    resetModel();
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_start_sel", 32'(bus.SEL_O), 32'h1);
    checkOutput("post_rst_start_write", 32'(bus.WRITE_O), 32'h1);
    checkOutput("post_rst_start_wdata", bus.WDATA_O, 32'h1);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      status_ready = ($urandom_range(0, 2) != 0);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
